// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between the fetch (i_*)
// and load/store (d_*) paths, with one transaction in flight and a response watchdog.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  i_valid,
  input  logic [ADDR_W-1:0]     i_addr,
  output logic                  i_ready,
  output logic                  i_rvalid,
  output logic [DATA_W-1:0]     i_rdata,
  input  logic                  d_valid,
  input  logic                  d_we,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  input  logic [DATA_W/8-1:0]   d_wstrb,
  output logic                  d_ready,
  output logic                  d_rvalid,
  output logic [DATA_W-1:0]     d_rdata,
  output logic                  mem_valid,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic [DATA_W/8-1:0]   mem_wstrb,
  input  logic                  mem_ready,
  input  logic                  mem_rvalid,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  err
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                owner_q, owner_d;   // 1 = load/store port
  logic                prio_d_q, prio_d_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                i_rvalid_q, i_rvalid_d;
  logic                d_rvalid_q, d_rvalid_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                err_q, err_d;

  logic                grant_i, grant_d;
  logic                timeout_hit;
  logic                respond;
  logic [DATA_W-1:0]   resp_data;

  assign grant_d = d_valid && (prio_d_q || !i_valid);
  assign grant_i = i_valid && !(d_valid && prio_d_q);
  assign i_ready = (state_q == IDLE) && grant_i;
  assign d_ready = (state_q == IDLE) && grant_d;

  // A response in the same cycle as the timeout takes precedence.
  assign timeout_hit = (TIMEOUT != 0) && !mem_rvalid && (cnt_q == CNT_W'(TIMEOUT - 1));

  assign mem_valid = (state_q == ISSUE);
  assign mem_we    = mem_valid && we_q;
  assign mem_addr  = mem_valid ? addr_q  : '0;
  assign mem_wdata = mem_valid ? wdata_q : '0;
  assign mem_wstrb = mem_valid ? wstrb_q : '0;

  assign i_rvalid = i_rvalid_q;
  assign d_rvalid = d_rvalid_q;
  assign i_rdata  = i_rdata_q;
  assign d_rdata  = d_rdata_q;
  assign err      = err_q;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    prio_d_d   = prio_d_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    cnt_d      = cnt_q;
    i_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    err_d      = 1'b0;
    respond    = 1'b0;
    resp_data  = '0;

    case (state_q)
      IDLE: begin
        if ((i_valid && i_ready) || (d_valid && d_ready)) begin
          state_d  = ISSUE;
          owner_d  = d_ready;
          prio_d_d = !d_ready;
          addr_d   = d_ready ? d_addr  : i_addr;
          we_d     = d_ready && d_we;
          wdata_d  = d_ready ? d_wdata : '0;
          wstrb_d  = (d_ready && d_we) ? d_wstrb : '0;
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          respond   = 1'b1;
          resp_data = we_q ? '0 : mem_rdata;
          state_d   = IDLE;
        end else if (timeout_hit) begin
          respond = 1'b1;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (respond) begin
      if (owner_q) begin
        d_rvalid_d = 1'b1;
        d_rdata_d  = resp_data;
      end else begin
        i_rvalid_d = 1'b1;
        i_rdata_d  = resp_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      prio_d_q   <= 1'b1;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      cnt_q      <= '0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      prio_d_q   <= prio_d_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      cnt_q      <= cnt_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: random requesters and a random memory,
// checked every cycle against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned NCYC    = 4000;

  logic              clk = 1'b0;
  logic              resetn;
  logic              i_valid, i_ready, i_rvalid;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_rdata;
  logic              d_valid, d_we, d_ready, d_rvalid;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic [3:0]        d_wstrb;
  logic              mem_valid, mem_we, mem_ready, mem_rvalid, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [3:0]        mem_wstrb;

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .resetn(resetn),
    .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_wstrb(d_wstrb), .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: an outstanding request (if any), whether memory has taken it,
  // how long we have waited, and the response the ports should show next cycle.
  typedef struct {
    bit               is_d;
    bit               we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wstrb;
  } req_t;

  req_t              pend[$];
  bit                m_taken, m_prio_d;
  int unsigned       m_waits;
  bit                e_irv, e_drv, e_err;
  logic [DATA_W-1:0] e_ird, e_drd;
  int unsigned       n_grant_i = 0, n_grant_d = 0, n_timeout = 0;

  task automatic model_reset();
    pend.delete();
    m_taken  = 0;
    m_prio_d = 1;
    m_waits  = 0;
    e_irv = 0; e_drv = 0; e_err = 0;
    e_ird = '0; e_drd = '0;
  endtask

  task automatic deliver(input bit is_d, input logic [DATA_W-1:0] data);
    if (is_d) begin e_drv = 1; e_drd = data; end
    else      begin e_irv = 1; e_ird = data; end
  endtask

  initial begin
    bit   win_i, win_d, issuing;
    req_t r;
    int unsigned busy_pct;

    resetn = 0; i_valid = 0; i_addr = '0; d_valid = 0; d_we = 0;
    d_addr = '0; d_wdata = '0; d_wstrb = '0;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
    model_reset();

    for (int unsigned cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      // Alternate between light traffic and saturated contention.
      busy_pct = ((cyc / 500) % 2 == 1) ? 100 : 40;
      resetn  = (cyc < 3) ? 1'b0 : ($urandom_range(0, 149) != 0);
      i_valid = ($urandom_range(0, 99) < busy_pct);
      i_addr  = $urandom();
      d_valid = ($urandom_range(0, 99) < busy_pct);
      d_we    = $urandom_range(0, 1);
      d_addr  = $urandom();
      d_wdata = $urandom();
      d_wstrb = d_we ? 4'($urandom_range(0, 15)) : 4'h0;
      issuing = (pend.size() != 0) && !m_taken;
      mem_ready = $urandom_range(0, 1);
      // The memory never answers while the request is still being offered.
      if (issuing)                mem_rvalid = 1'b0;
      else if (pend.size() != 0)  mem_rvalid = ($urandom_range(0, 3) == 0);
      else                        mem_rvalid = ($urandom_range(0, 7) == 0);
      mem_rdata = $urandom();
      #1;

      win_d = d_valid && (m_prio_d || !i_valid);
      win_i = i_valid && !win_d;
      check("i_ready",   64'(i_ready),   64'(pend.size() == 0 && win_i));
      check("d_ready",   64'(d_ready),   64'(pend.size() == 0 && win_d));
      check("mem_valid", 64'(mem_valid), 64'(issuing));
      if (issuing) r = pend[0];
      else begin r.is_d = 0; r.we = 0; r.addr = '0; r.wdata = '0; r.wstrb = '0; end
      check("mem_we",    64'(mem_we),    64'(r.we));
      check("mem_addr",  64'(mem_addr),  64'(r.addr));
      check("mem_wdata", 64'(mem_wdata), 64'(r.wdata));
      check("mem_wstrb", 64'(mem_wstrb), 64'(r.wstrb));
      check("i_rvalid",  64'(i_rvalid),  64'(e_irv));
      check("i_rdata",   64'(i_rdata),   64'(e_ird));
      check("d_rvalid",  64'(d_rvalid),  64'(e_drv));
      check("d_rdata",   64'(d_rdata),   64'(e_drd));
      check("err",       64'(err),       64'(e_err));

      // Advance the model to the state after the coming posedge.
      e_irv = 0; e_drv = 0; e_err = 0;
      if (!resetn) begin
        model_reset();
      end else if (pend.size() == 0) begin
        if (win_i || win_d) begin
          r.is_d  = win_d;
          r.addr  = win_d ? d_addr : i_addr;
          r.we    = win_d && d_we;
          r.wdata = win_d ? d_wdata : '0;
          r.wstrb = (win_d && d_we) ? d_wstrb : 4'h0;
          pend.push_back(r);
          m_prio_d = !win_d;
          m_taken  = 0;
          if (win_d) n_grant_d++; else n_grant_i++;
        end
      end else if (!m_taken) begin
        if (mem_ready) begin m_taken = 1; m_waits = 0; end
      end else begin
        r = pend[0];
        if (mem_rvalid) begin
          deliver(r.is_d, r.we ? '0 : mem_rdata);
          void'(pend.pop_front());
        end else begin
          m_waits++;
          if (m_waits == TIMEOUT) begin
            deliver(r.is_d, '0);
            e_err = 1;
            n_timeout++;
            void'(pend.pop_front());
          end
        end
      end
    end

    // Make sure the random run actually reached the interesting cases.
    check("saw_fetch_grants", 64'(n_grant_i > 20), 64'd1);
    check("saw_data_grants",  64'(n_grant_d > 20), 64'd1);
    check("saw_timeouts",     64'(n_timeout > 5),  64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
